id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits, register index 5 bits, ALU op 4 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 in_valid  in  1  decode stage offers an instruction; in_ready  out  1  stage can accept.
REQ-005 in_rs_data, in_rt_data  in  32  register-file read data; in_rs, in_rt, in_rd  in  5  register indices.
REQ-006 in_imm  in  16  instruction immediate; in_alu_src  in  1  1 = immediate replaces rt operand.
REQ-007 in_aluop  in  2  00 add, 01 sub, 10 decode in_funct, 11 reserved; in_funct  in  6  R-type function field.
REQ-008 in_reg_write  in  1  instruction writes a register; in_reg_dst  in  1  1 = dest is rd, 0 = rt.
REQ-009 exmem_reg_write  in  1, exmem_rd  in  5, exmem_result  in  32  EX/MEM forwarding source.
REQ-010 memwb_reg_write  in  1, memwb_rd  in  5, memwb_result  in  32  MEM/WB forwarding source.
REQ-011 flush  in  1  discard held and incoming instruction.
REQ-012 out_valid  out  1, out_ready  in  1  handshake to ALU stage.
REQ-013 alu_data1, alu_data2  out  32  ALU operands; alu_op  out  4  ALU operation code.
REQ-014 out_store_data  out  32  forwarded rt value; out_wr_reg  out  5; out_reg_write  out  1; out_illegal  out  1.
REQ-015 illegal_count  out  8  saturating count of accepted illegal instructions.

Function
REQ-016 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-017 Accept SHALL occur on a rising edge with in_valid && in_ready; all output registers load the decoded instruction, out_valid becomes 1; latency exactly one cycle.
REQ-018 With out_valid && !out_ready, all outputs SHALL hold stable.
REQ-019 out_valid && out_ready && !accept SHALL clear out_valid; data outputs may hold stale values.
REQ-020 flush SHALL clear out_valid next edge and block acceptance; flush dominates all other events.
REQ-021 Forwarded rs = exmem_result if exmem_reg_write && exmem_rd == in_rs && in_rs != 0; else memwb_result under same test on MEM/WB; else in_rs_data; same rule for rt; sampled at accept edge only.
REQ-022 Register index 0 SHALL never be forwarded; its read data passes unchanged.
REQ-023 alu_data1 = forwarded rs; alu_data2 = sign-extended in_imm if in_alu_src else forwarded rt; out_store_data = forwarded rt always.
REQ-024 out_wr_reg = in_rd if in_reg_dst else in_rt; out_reg_write = in_reg_write && !illegal.
REQ-025 alu_op mapping: aluop 00 -> 0010; 01 -> 0110; 10 with funct 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100.
REQ-026 Illegal = aluop 11 or aluop 10 with unlisted funct; SHALL register alu_op 1111 (ALU yields 0), out_illegal 1, out_reg_write 0.
REQ-027 illegal_count SHALL increment by 1 per accepted illegal instruction, saturating at 255; flushed/unaccepted instructions not counted.

Reset
REQ-028 rst SHALL dominate flush and accept; next edge: out_valid 0, alu_data1/alu_data2/out_store_data 0, alu_op 0000, out_wr_reg 0, out_reg_write 0, out_illegal 0, illegal_count 0.
REQ-029 in_ready during rst SHALL follow REQ-016 from reset-cleared state; no instruction accepted on reset edge.

Verification
REQ-030 R-type add, rs=5 data 7, rt=6 data 9, rd=3, out_ready 1 -> next cycle out_valid 1, alu_data1 7, alu_data2 9, alu_op 0010, out_wr_reg 3, out_reg_write 1.
REQ-031 in_alu_src 1, in_imm 0xFFFC -> alu_data2 0xFFFFFFFC; aluop 01 -> alu_op 0110.
REQ-032 in_rs=4, exmem (1,4,0x11), memwb (1,4,0x22) -> alu_data1 0x11; exmem_reg_write 0 -> 0x22; in_rs=0 with both matching 0 -> in_rs_data.
REQ-033 out_ready 0 two cycles with in_valid 1 -> in_ready 0, outputs unchanged; out_ready 1 -> new instruction loaded next edge.
REQ-034 funct 000000 aluop 10 accepted 300 times -> alu_op 1111, out_illegal 1, out_reg_write 0, illegal_count 255.
REQ-035 flush with out_valid 1 and in_valid 1 -> out_valid 0 next edge, no accept; rst mid-stall -> all outputs per REQ-028.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, ALU-op decode and illegal-op counting
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    input  logic        in_alu_src,
    input  logic [1:0]  in_aluop,
    input  logic [5:0]  in_funct,
    input  logic        in_reg_write,
    input  logic        in_reg_dst,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [3:0]  alu_op,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_wr_reg,
    output logic        out_reg_write,
    output logic        out_illegal,
    output logic [7:0]  illegal_count
);
    logic        r_valid;
    logic [31:0] r_data1;
    logic [31:0] r_data2;
    logic [3:0]  r_op;
    logic [31:0] r_store;
    logic [4:0]  r_wr;
    logic        r_rw;
    logic        r_ill;
    logic [7:0]  r_cnt;
    logic        w_accept;
    logic [31:0] w_fwd_rs;
    logic [31:0] w_fwd_rt;
    logic [31:0] w_imm_ext;
    logic [3:0]  w_funct_op;
    logic [3:0]  w_op;
    logic        w_illegal;

    // Handshake: a flush blocks acceptance; a held result must drain first
    always_comb begin
        in_ready = (!r_valid || out_ready) && !flush;
        w_accept = in_valid && in_ready;
    end

    // Forwarding: EX/MEM beats MEM/WB beats the register file; register 0 is never forwarded
    always_comb begin
        w_fwd_rs  = (exmem_reg_write && exmem_rd == in_rs && in_rs != 5'd0) ? exmem_result :
                    (memwb_reg_write && memwb_rd == in_rs && in_rs != 5'd0) ? memwb_result : in_rs_data;
        w_fwd_rt  = (exmem_reg_write && exmem_rd == in_rt && in_rt != 5'd0) ? exmem_result :
                    (memwb_reg_write && memwb_rd == in_rt && in_rt != 5'd0) ? memwb_result : in_rt_data;
        w_imm_ext = {{16{in_imm[15]}}, in_imm};
    end

    // ALU-op decode; 1111 is reserved for illegal encodings so it doubles as the illegal flag
    always_comb begin
        w_funct_op = (in_funct == 6'b100000) ? 4'b0010 :
                     (in_funct == 6'b100010) ? 4'b0110 :
                     (in_funct == 6'b100100) ? 4'b0000 :
                     (in_funct == 6'b100101) ? 4'b0001 :
                     (in_funct == 6'b101010) ? 4'b0111 :
                     (in_funct == 6'b100111) ? 4'b1100 : 4'b1111;
        w_op       = (in_aluop == 2'b00) ? 4'b0010 :
                     (in_aluop == 2'b01) ? 4'b0110 :
                     (in_aluop == 2'b10) ? w_funct_op : 4'b1111;
        w_illegal  = (w_op == 4'b1111);
    end

    // Pipeline register: reset beats flush beats accept beats drain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data1 <= '0;
            r_data2 <= '0;
            r_op    <= '0;
            r_store <= '0;
            r_wr    <= '0;
            r_rw    <= 1'b0;
            r_ill   <= 1'b0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data1 <= w_fwd_rs;
            r_data2 <= in_alu_src ? w_imm_ext : w_fwd_rt;
            r_op    <= w_op;
            r_store <= w_fwd_rt;
            r_wr    <= in_reg_dst ? in_rd : in_rt;
            r_rw    <= in_reg_write && !w_illegal;
            r_ill   <= w_illegal;
            r_cnt   <= (w_illegal && r_cnt != 8'hFF) ? r_cnt + 8'd1 : r_cnt;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Outputs come straight from the registers
    always_comb begin
        out_valid      = r_valid;
        alu_data1      = r_data1;
        alu_data2      = r_data2;
        alu_op         = r_op;
        out_store_data = r_store;
        out_wr_reg     = r_wr;
        out_reg_write  = r_rw;
        out_illegal    = r_ill;
        illegal_count  = r_cnt;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_alu_src, in_reg_write, in_reg_dst;
    logic [31:0] in_rs_data, in_rt_data, exmem_result, memwb_result;
    logic [4:0]  in_rs, in_rt, in_rd, exmem_rd, memwb_rd;
    logic [15:0] in_imm;
    logic [1:0]  in_aluop;
    logic [5:0]  in_funct;
    logic        exmem_reg_write, memwb_reg_write, flush, out_valid, out_ready;
    logic [31:0] alu_data1, alu_data2, out_store_data;
    logic [3:0]  alu_op;
    logic [4:0]  out_wr_reg;
    logic        out_reg_write, out_illegal;
    logic [7:0]  illegal_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic        m_valid, m_rw, m_ill;
    logic [31:0] m_d1, m_d2, m_sd;
    logic [3:0]  m_op;
    logic [4:0]  m_wr;
    int          m_cnt;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_alu_src(in_alu_src), .in_aluop(in_aluop), .in_funct(in_funct),
        .in_reg_write(in_reg_write), .in_reg_dst(in_reg_dst),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
        .out_store_data(out_store_data), .out_wr_reg(out_wr_reg),
        .out_reg_write(out_reg_write), .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_illegal(input logic [1:0] aluop, input logic [5:0] funct);
        if (aluop == 2'd3) return 1'b1;
        if (aluop == 2'd2)
            return !(funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27});
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_op(input logic [1:0] aluop, input logic [5:0] funct);
        if (is_illegal(aluop, funct)) return 4'hF;
        if (aluop == 2'd0) return 4'h2;
        if (aluop == 2'd1) return 4'h6;
        case (funct)
            6'h20:   return 4'h2;
            6'h22:   return 4'h6;
            6'h24:   return 4'h0;
            6'h25:   return 4'h1;
            6'h2A:   return 4'h7;
            default: return 4'hC;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd == idx) return memwb_result;
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_d1 = 0; m_d2 = 0; m_sd = 0; m_op = 0; m_wr = 0; m_rw = 0; m_ill = 0; m_cnt = 0;
    endtask

    task automatic chk_out(input bit all);
        chk("out_valid", out_valid, m_valid);
        chk("illegal_count", illegal_count, m_cnt[7:0]);
        if (m_valid || all) begin
            chk("alu_data1", alu_data1, m_d1);
            chk("alu_data2", alu_data2, m_d2);
            chk("out_store_data", out_store_data, m_sd);
            chk("alu_op", alu_op, m_op);
            chk("out_wr_reg", out_wr_reg, m_wr);
            chk("out_reg_write", out_reg_write, m_rw);
            chk("out_illegal", out_illegal, m_ill);
        end
    endtask

    task automatic step();
        logic rdy;
        bit   ill;
        #1;
        rdy = (!m_valid || out_ready) && !flush;
        chk("in_ready", in_ready, rdy);
        if (rst) model_reset();
        else if (flush) m_valid = 0;
        else if (in_valid && rdy) begin
            ill     = is_illegal(in_aluop, in_funct);
            m_valid = 1;
            m_d1    = ref_fwd(in_rs, in_rs_data);
            m_sd    = ref_fwd(in_rt, in_rt_data);
            m_d2    = in_alu_src ? 32'($signed(in_imm)) : m_sd;
            m_op    = ref_op(in_aluop, in_funct);
            m_wr    = in_reg_dst ? in_rd : in_rt;
            m_rw    = in_reg_write && !ill;
            m_ill   = ill;
            if (ill && m_cnt < 255) m_cnt++;
        end else if (out_ready) m_valid = 0;
        @(posedge clk);
        #1;
        chk_out(rst);
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; flush = 0; out_ready = 1;
        in_rs_data = 0; in_rt_data = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0;
        in_alu_src = 0; in_aluop = 0; in_funct = 0; in_reg_write = 0; in_reg_dst = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic instr(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                         input logic [31:0] rtd, input logic [4:0] rd, input logic [15:0] imm,
                         input logic src, input logic [1:0] op, input logic [5:0] fn);
        in_valid = 1; in_rs = rs; in_rs_data = rsd; in_rt = rt; in_rt_data = rtd; in_rd = rd;
        in_imm = imm; in_alu_src = src; in_aluop = op; in_funct = fn; in_reg_write = 1; in_reg_dst = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk_out(1);
        step();
        rst = 0;

        instr(5, 7, 6, 9, 3, 0, 0, 2'b10, 6'h20);
        step();
        chk("r_type_d1", alu_data1, 7);
        chk("r_type_d2", alu_data2, 9);
        chk("r_type_op", alu_op, 4'b0010);
        chk("r_type_wr", out_wr_reg, 3);
        chk("r_type_rw", out_reg_write, 1);

        instr(1, 100, 2, 5, 4, 16'hFFFC, 1, 2'b01, 0);
        step();
        chk("imm_d2", alu_data2, 32'hFFFFFFFC);
        chk("sub_op", alu_op, 4'b0110);

        instr(4, 1, 7, 2, 8, 0, 0, 2'b00, 0);
        exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'h22;
        step();
        chk("fwd_exmem", alu_data1, 32'h11);
        exmem_reg_write = 0;
        step();
        chk("fwd_memwb", alu_data1, 32'h22);
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0; in_rs = 0; in_rs_data = 32'h55;
        step();
        chk("fwd_r0", alu_data1, 32'h55);
        exmem_reg_write = 0; memwb_reg_write = 0;

        instr(9, 32'hAAAA, 10, 32'hBBBB, 11, 0, 0, 2'b10, 6'h24);
        step();
        out_ready = 0;
        instr(12, 1, 13, 2, 14, 0, 0, 2'b10, 6'h25);
        step();
        step();
        chk("stall_hold_d1", alu_data1, 32'hAAAA);
        out_ready = 1;
        step();
        chk("stall_release_op", alu_op, 4'b0001);

        instr(1, 1, 2, 2, 3, 0, 0, 2'b10, 6'h00);
        repeat (300) step();
        chk("illegal_op", alu_op, 4'b1111);
        chk("illegal_flag", out_illegal, 1);
        chk("illegal_rw", out_reg_write, 0);
        chk("illegal_sat", illegal_count, 255);

        instr(3, 3, 4, 4, 5, 0, 0, 2'b00, 0);
        flush = 1;
        step();
        chk("flush_valid", out_valid, 0);
        flush = 0;
        step();
        out_ready = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        chk("rst_stall_cnt", illegal_count, 0);

        for (int i = 0; i < 1500; i++) begin
            in_valid        = ($urandom_range(0, 9) < 7);
            out_ready       = ($urandom_range(0, 9) < 7);
            flush           = ($urandom_range(0, 19) == 0);
            rst             = ($urandom_range(0, 49) == 0);
            in_rs           = 5'($urandom_range(0, 3));
            in_rt           = 5'($urandom_range(0, 3));
            in_rd           = 5'($urandom);
            in_rs_data      = $urandom;
            in_rt_data      = $urandom;
            in_imm          = 16'($urandom);
            in_alu_src      = 1'($urandom);
            in_aluop        = 2'($urandom);
            in_funct        = ($urandom_range(0, 3) == 0) ? 6'($urandom) :
                              6'h20 + 6'($urandom_range(0, 10));
            in_reg_write    = 1'($urandom);
            in_reg_dst      = 1'($urandom);
            exmem_reg_write = 1'($urandom);
            exmem_rd        = 5'($urandom_range(0, 3));
            exmem_result    = $urandom;
            memwb_reg_write = 1'($urandom);
            memwb_rd        = 5'($urandom_range(0, 3));
            memwb_result    = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
